// File: rtl/gate_activation_unit.sv
// Bias-add and piecewise-linear activation stage for the LSTM datapath.
// Collects a full row vector from the multiplier, then streams it out in BANDWIDTH-wide chunks.
module gate_activation_unit #(
  parameter int MAX_ROWS   = 64,
  parameter int BANDWIDTH  = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(MAX_ROWS):0]     num_rows,
  input  logic [1:0]                    act_sel,
  input  logic                          bias_we,
  input  logic [$clog2(MAX_ROWS)-1:0]   bias_addr,
  input  logic signed [DATA_WIDTH-1:0]  bias_data,
  input  logic signed [DATA_WIDTH-1:0]  result_in,
  input  logic                          result_valid_in,
  input  logic                          vec_ready,
  output logic                          vec_write_enable,
  output logic [$clog2(MAX_ROWS)-1:0]   vec_base_addr,
  output logic signed [DATA_WIDTH-1:0]  vec_out [0:BANDWIDTH-1],
  output logic                          busy,
  output logic                          done
);

  localparam int AW = $clog2(MAX_ROWS);
  localparam int NW = AW + 1;
  localparam logic signed [DATA_WIDTH-1:0] Q_ZERO    = '0;
  localparam logic signed [DATA_WIDTH-1:0] Q_ONE     = DATA_WIDTH'(4096);
  localparam logic signed [DATA_WIDTH-1:0] Q_NEG_ONE = DATA_WIDTH'(-4096);
  localparam logic signed [DATA_WIDTH-1:0] Q_HALF    = DATA_WIDTH'(2048);
  localparam logic signed [DATA_WIDTH-1:0] Q_MAX     = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] Q_MIN     = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE, ST_COLLECT, ST_DRAIN, ST_EMIT, ST_DONE
  } state_t;

  // Add at one extra bit, then clamp to the representable Q4.12 range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] sum;
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      sat_add = sum[DATA_WIDTH] ? Q_MIN : Q_MAX;
    end else begin
      sat_add = sum[DATA_WIDTH-1:0];
    end
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] activate(
    input logic [1:0]                   sel,
    input logic signed [DATA_WIDTH-1:0] s
  );
    logic signed [DATA_WIDTH-1:0] hs;
    hs = (s >>> 2'd2) + Q_HALF;
    case (sel)
      2'd1: begin
        if (hs < Q_ZERO)     activate = Q_ZERO;
        else if (hs > Q_ONE) activate = Q_ONE;
        else                 activate = hs;
      end
      2'd2: begin
        if (s < Q_NEG_ONE)   activate = Q_NEG_ONE;
        else if (s > Q_ONE)  activate = Q_ONE;
        else                 activate = s;
      end
      default: activate = s;
    endcase
  endfunction

  state_t                       state_r, state_n;
  logic [NW-1:0]                num_rows_r;
  logic [1:0]                   act_sel_r;
  logic [AW-1:0]                row_cnt_r;
  logic                         drain_cnt_r;
  logic [NW-1:0]                base_r;
  logic                         s1_valid_r;
  logic signed [DATA_WIDTH-1:0] s1_data_r;
  logic [AW-1:0]                s1_idx_r;
  logic signed [DATA_WIDTH-1:0] bias_mem [0:MAX_ROWS-1];
  logic signed [DATA_WIDTH-1:0] out_buf  [0:MAX_ROWS-1];

  logic accept_s;
  logic last_row_s;
  logic last_chunk_s;

  assign accept_s     = (state_r == ST_COLLECT) && result_valid_in;
  assign last_row_s   = ({1'b0, row_cnt_r} + NW'(1)) >= num_rows_r;
  assign last_chunk_s = (32'(base_r) + 32'(BANDWIDTH)) >= 32'(num_rows_r);

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE:    if (start) state_n = ST_COLLECT; else state_n = ST_IDLE;
      ST_COLLECT: if (accept_s && last_row_s) state_n = ST_DRAIN; else state_n = ST_COLLECT;
      ST_DRAIN:   if (drain_cnt_r) state_n = ST_EMIT; else state_n = ST_DRAIN;
      ST_EMIT:    if (vec_write_enable && last_chunk_s) state_n = ST_DONE; else state_n = ST_EMIT;
      ST_DONE:    state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // State, pass configuration, counters and the stage-1 pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      num_rows_r  <= '0;
      act_sel_r   <= 2'd0;
      row_cnt_r   <= '0;
      drain_cnt_r <= 1'b0;
      base_r      <= '0;
      s1_valid_r  <= 1'b0;
      s1_data_r   <= '0;
      s1_idx_r    <= '0;
    end else begin
      state_r     <= state_n;
      s1_valid_r  <= accept_s;
      drain_cnt_r <= (state_r == ST_DRAIN) ? ~drain_cnt_r : 1'b0;
      if (state_r == ST_IDLE && start) begin
        num_rows_r <= num_rows;
        act_sel_r  <= act_sel;
        row_cnt_r  <= '0;
        base_r     <= '0;
      end
      if (accept_s) begin
        row_cnt_r <= row_cnt_r + AW'(1);
        s1_data_r <= sat_add(result_in, bias_mem[row_cnt_r]);
        s1_idx_r  <= row_cnt_r;
      end
      if (vec_write_enable) begin
        base_r <= base_r + NW'(BANDWIDTH);
      end
    end
  end

  // Storage arrays carry no reset; bias persists across passes.
  always_ff @(posedge clk) begin
    if (state_r == ST_IDLE && bias_we) begin
      bias_mem[bias_addr] <= bias_data;
    end
    if (s1_valid_r) begin
      out_buf[s1_idx_r] <= activate(act_sel_r, s1_data_r);
    end
  end

  // Chunk presentation; lanes past the vector end read as zero.
  always_comb begin
    logic [31:0] lane_s;
    lane_s           = '0;
    vec_write_enable = (state_r == ST_EMIT) && vec_ready;
    busy             = (state_r != ST_IDLE);
    done             = (state_r == ST_DONE);
    if (state_r == ST_EMIT) begin
      vec_base_addr = base_r[AW-1:0];
    end else begin
      vec_base_addr = '0;
    end
    for (int j = 0; j < BANDWIDTH; j++) begin
      lane_s = 32'(base_r) + 32'(j);
      if (state_r == ST_EMIT && lane_s < 32'(num_rows_r)) begin
        vec_out[j] = out_buf[lane_s[AW-1:0]];
      end else begin
        vec_out[j] = '0;
      end
    end
  end

endmodule

// File: tb/tb_gate_activation_unit.sv
// Directed self-checking bench for gate_activation_unit with hand-computed Q4.12 results.
module tb_gate_activation_unit;

  localparam int MR = 64;
  localparam int BW = 16;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [6:0]           num_rows = 7'd0;
  logic [1:0]           act_sel = 2'd0;
  logic                 bias_we = 1'b0;
  logic [5:0]           bias_addr = 6'd0;
  logic signed [DW-1:0] bias_data = '0;
  logic signed [DW-1:0] result_in = '0;
  logic                 result_valid_in = 1'b0;
  logic                 vec_ready = 1'b1;
  logic                 vec_write_enable;
  logic [5:0]           vec_base_addr;
  logic signed [DW-1:0] vec_out [0:BW-1];
  logic                 busy;
  logic                 done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  gate_activation_unit #(.MAX_ROWS(MR), .BANDWIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .act_sel(act_sel),
    .bias_we(bias_we), .bias_addr(bias_addr), .bias_data(bias_data),
    .result_in(result_in), .result_valid_in(result_valid_in), .vec_ready(vec_ready),
    .vec_write_enable(vec_write_enable), .vec_base_addr(vec_base_addr),
    .vec_out(vec_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at the falling edge where a chunk is offered, or after a bounded wait.
  task automatic wait_we(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!vec_write_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_value(tag, int'(vec_write_enable), 1);
  endtask

  // One-row pass; the bias is written in the same cycle as start.
  task automatic run_single(input string tag, input logic [15:0] b, input logic [1:0] sel,
                            input logic [15:0] r, input int exp);
    start = 1'b1; num_rows = 7'd1; act_sel = sel;
    bias_we = 1'b1; bias_addr = 6'd0; bias_data = b;
    tick();
    start = 1'b0; bias_we = 1'b0;
    check_value({tag, "_busy"}, int'(busy), 1);
    result_in = r; result_valid_in = 1'b1;
    tick();
    result_valid_in = 1'b0;
    wait_we({tag, "_we"});
    check_value({tag, "_base"}, int'(vec_base_addr), 0);
    check_value({tag, "_lane0"}, int'(vec_out[0]), exp);
    check_value({tag, "_lane1"}, int'(vec_out[1]), 0);
    check_value({tag, "_lane15"}, int'(vec_out[15]), 0);
    tick();
    check_value({tag, "_done"}, int'(done), 1);
    tick();
    check_value({tag, "_done_clr"}, int'(done), 0);
    check_value({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int last_cyc;
    int seen_done;
    #3;
    check_value("rst_busy", int'(busy), 0);
    check_value("rst_done", int'(done), 0);
    check_value("rst_we", int'(vec_write_enable), 0);
    check_value("rst_base", int'(vec_base_addr), 0);
    check_value("rst_lane0", int'(vec_out[0]), 0);
    #9 rst_n = 1'b1;
    tick();

    run_single("sig_basic", 16'h0800, 2'd1, 16'h1000, 3584);
    run_single("tanh_sat", 16'h2000, 2'd2, 16'h7000, 4096);
    run_single("sig_low", 16'h0000, 2'd1, 16'(-20000), 0);
    run_single("none_min", 16'h8000, 2'd0, 16'h8000, -32768);
    run_single("sel3", 16'h0100, 2'd3, 16'(-512), -256);

    // Multi-chunk vector with backpressure.
    for (int i = 0; i < 20; i++) begin
      bias_we = 1'b1; bias_addr = 6'(i); bias_data = '0;
      tick();
    end
    bias_we = 1'b0;
    start = 1'b1; num_rows = 7'd20; act_sel = 2'd0;
    tick();
    start = 1'b0;
    last_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      result_in = 16'(i + 1); result_valid_in = 1'b1;
      last_cyc = cyc;
      tick();
    end
    result_valid_in = 1'b0;
    wait_we("mc_we0");
    check_value("mc_latency_ge3", int'((cyc - last_cyc) >= 3), 1);
    check_value("mc_base0", int'(vec_base_addr), 0);
    for (int j = 0; j < BW; j++) check_value($sformatf("mc_c0_lane%0d", j), int'(vec_out[j]), j + 1);
    tick();
    vec_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_value($sformatf("bp_we_%0d", k), int'(vec_write_enable), 0);
      check_value($sformatf("bp_base_%0d", k), int'(vec_base_addr), 16);
      check_value($sformatf("bp_lane0_%0d", k), int'(vec_out[0]), 17);
      check_value($sformatf("bp_lane4_%0d", k), int'(vec_out[4]), 0);
    end
    tick();
    vec_ready = 1'b1;
    @(negedge clk);
    check_value("mc_we1", int'(vec_write_enable), 1);
    check_value("mc_base1", int'(vec_base_addr), 16);
    for (int j = 0; j < BW; j++)
      check_value($sformatf("mc_c1_lane%0d", j), int'(vec_out[j]), (j < 4) ? 17 + j : 0);
    tick();
    check_value("mc_done", int'(done), 1);
    tick();
    check_value("mc_idle", int'(busy), 0);

    // Ignored inputs: results in IDLE, start/bias_we while busy, a 17th result.
    result_in = 16'd777; result_valid_in = 1'b1;
    repeat (3) tick();
    result_valid_in = 1'b0;
    check_value("ign_idle_busy", int'(busy), 0);
    start = 1'b1; num_rows = 7'd16; act_sel = 2'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      result_in = 16'((i < 16) ? 100 + i : 999); result_valid_in = 1'b1;
      if (i == 8) begin
        start = 1'b1; num_rows = 7'd1; act_sel = 2'd1;
        bias_we = 1'b1; bias_addr = 6'd12; bias_data = 16'h0100;
      end
      tick();
      start = 1'b0; bias_we = 1'b0;
    end
    result_valid_in = 1'b0;
    wait_we("ign_we");
    check_value("ign_base", int'(vec_base_addr), 0);
    for (int j = 0; j < BW; j++) check_value($sformatf("ign_lane%0d", j), int'(vec_out[j]), 100 + j);
    tick();
    check_value("ign_done", int'(done), 1);
    tick();
    check_value("ign_idle", int'(busy), 0);

    // Reset in the middle of COLLECT.
    start = 1'b1; num_rows = 7'd16; act_sel = 2'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      result_in = 16'(i); result_valid_in = 1'b1;
      tick();
    end
    result_valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check_value("mrst_busy", int'(busy), 0);
    check_value("mrst_we", int'(vec_write_enable), 0);
    check_value("mrst_base", int'(vec_base_addr), 0);
    check_value("mrst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check_value("mrst_no_done", seen_done, 0);
    tick();
    run_single("post_rst", 16'h0200, 2'd2, 16'h0300, 1280);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1);
  end

endmodule
